// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle: master drives the address phase,
// slave answers with addr_ok, data_ok and rdata.
interface sram_req_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like bus between the IF and EXE requesters, with request locking and an
// in-order tag FIFO for response steering. Optional macro: ARB_ROUND_ROBIN_EN.
module sram_req_arbiter #(
   parameter int MAX_OUT = 4,
   parameter int TAG_AW  = 2
) (
   input  logic               clk,
   input  logic               resetn,
   sram_req_arbiter_if.slave  inst,
   sram_req_arbiter_if.slave  data,
   sram_req_arbiter_if.master bus
);

   typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_t;
   typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_t;

   localparam logic [TAG_AW:0]   CNT_FULL = (TAG_AW+1)'(MAX_OUT);
   localparam logic [TAG_AW-1:0] PTR_LAST = TAG_AW'(MAX_OUT - 1);

   lock_t             r_lock_state;
   lock_t             w_lock_next;
   src_t              r_grant;
   src_t              w_grant;
   logic [TAG_AW-1:0] r_wptr;
   logic [TAG_AW-1:0] r_rptr;
   logic [TAG_AW:0]   r_out_cnt;
   logic              r_tag_mem [MAX_OUT];

   logic w_granted_req;
   logic w_full;
   logic w_bus_req;
   logic w_push;
   logic w_pop;
   logic w_head_tag;

`ifdef ARB_ROUND_ROBIN_EN
   src_t r_rr_last;

   always_ff @(posedge clk) begin
      if (!resetn)
         r_rr_last <= SRC_INST;
      else if (w_push)
         r_rr_last <= w_grant;
   end

   // While locked the grant is frozen so a late requester cannot steal the address phase.
   always_comb begin
      w_grant = r_grant;
      if (r_lock_state == ST_OPEN) begin
         if (data.req && inst.req)
            w_grant = (r_rr_last == SRC_DATA) ? SRC_INST : SRC_DATA;
         else if (data.req)
            w_grant = SRC_DATA;
         else if (inst.req)
            w_grant = SRC_INST;
      end
   end
`else
   // While locked the grant is frozen so a late requester cannot steal the address phase.
   always_comb begin
      w_grant = r_grant;
      if (r_lock_state == ST_OPEN) begin
         if (data.req)
            w_grant = SRC_DATA;
         else if (inst.req)
            w_grant = SRC_INST;
      end
   end
`endif

   assign w_granted_req = (w_grant == SRC_DATA) ? data.req : inst.req;
   assign w_full        = (r_out_cnt == CNT_FULL);
   assign w_bus_req     = w_granted_req & ~w_full;
   assign w_push        = w_bus_req & bus.addr_ok;
   assign w_pop         = bus.data_ok & (r_out_cnt != '0);
   assign w_head_tag    = r_tag_mem[r_rptr];

   assign bus.req   = w_bus_req;
   assign bus.wr    = w_bus_req & ((w_grant == SRC_DATA) ? data.wr : inst.wr);
   assign bus.size  = w_bus_req ? ((w_grant == SRC_DATA) ? data.size  : inst.size)  : 2'd0;
   assign bus.addr  = w_bus_req ? ((w_grant == SRC_DATA) ? data.addr  : inst.addr)  : 32'd0;
   assign bus.wdata = w_bus_req ? ((w_grant == SRC_DATA) ? data.wdata : inst.wdata) : 32'd0;

   assign inst.addr_ok = w_push & (w_grant == SRC_INST);
   assign data.addr_ok = w_push & (w_grant == SRC_DATA);

   // A beat arriving with nothing outstanding is a protocol error and is dropped.
   assign inst.data_ok = w_pop & (w_head_tag == SRC_INST);
   assign data.data_ok = w_pop & (w_head_tag == SRC_DATA);
   assign inst.rdata   = bus.rdata;
   assign data.rdata   = bus.rdata;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_lock_state <= ST_OPEN;
         r_grant      <= SRC_DATA;
      end else begin
         r_lock_state <= w_lock_next;
         r_grant      <= w_grant;
      end
   end

   always_comb begin
      w_lock_next = r_lock_state;
      case (r_lock_state)
         ST_OPEN:   if (w_bus_req && !bus.addr_ok) w_lock_next = ST_LOCKED;
         ST_LOCKED: if (w_push)                    w_lock_next = ST_OPEN;
         default:   w_lock_next = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_tag_mem[r_wptr] <= w_grant;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_push)
            r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
            2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed bus scenarios with a tag scoreboard
// filled at each expected address handshake and drained at each response beat.
`timescale 1ns/1ps
module tb_sram_req_arbiter;

   localparam logic [31:0] IA       = 32'hBFC0_0000;
   localparam logic [31:0] DA       = 32'h8000_1000;
   localparam logic [31:0] I_WDATA  = 32'h1111_1111;
   localparam logic [31:0] D_WDATA  = 32'hCAFE_F00D;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   sram_req_arbiter_if inst_if ();
   sram_req_arbiter_if data_if ();
   sram_req_arbiter_if bus_if ();

   sram_req_arbiter #(.MAX_OUT(4), .TAG_AW(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .inst   (inst_if),
      .data   (data_if),
      .bus    (bus_if)
   );

   int n_checks = 0;
   int n_fails  = 0;
   bit exp_q[$];   // expected source per outstanding address phase: 0=inst, 1=data

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                        input logic [31:0] daddr, input logic aok, input logic dok,
                        input logic [31:0] rdata);
      @(posedge clk); #1;
      inst_if.req     = ireq;
      inst_if.addr    = iaddr;
      data_if.req     = dreq;
      data_if.addr    = daddr;
      bus_if.addr_ok  = aok;
      bus_if.data_ok  = dok;
      bus_if.rdata    = rdata;
      @(negedge clk);
   endtask

   task automatic expect_hs(input bit src, input logic [31:0] addr);
      $display("HS   src=%s addr=0x%08h bus_addr=0x%08h", src ? "DATA" : "INST", addr, bus_if.addr);
      check_val("hs_bus_req",  bus_if.req,  1);
      check_val("hs_bus_addr", bus_if.addr, addr);
      check_val("hs_bus_wr",   bus_if.wr,   src ? 1 : 0);
      check_val("hs_bus_size", bus_if.size, src ? 1 : 2);
      check_val("hs_wdata",    bus_if.wdata, src ? D_WDATA : I_WDATA);
      check_val("hs_inst_aok", inst_if.addr_ok, src ? 0 : 1);
      check_val("hs_data_aok", data_if.addr_ok, src ? 1 : 0);
      exp_q.push_back(src);
   endtask

   task automatic expect_blocked(input string tag);
      $display("BLK  %s bus_req=%0b", tag, bus_if.req);
      check_val({tag, "_bus_req"},  bus_if.req,      0);
      check_val({tag, "_inst_aok"}, inst_if.addr_ok, 0);
      check_val({tag, "_data_aok"}, data_if.addr_ok, 0);
   endtask

   task automatic expect_resp(input logic [31:0] rdata);
      bit src;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL resp_underflow: got beat 0x%08h expected no outstanding", rdata);
      end else begin
         src = exp_q.pop_front();
         $display("RESP src=%s rdata=0x%08h", src ? "DATA" : "INST", rdata);
         check_val("resp_inst_dok", inst_if.data_ok, src ? 0 : 1);
         check_val("resp_data_dok", data_if.data_ok, src ? 1 : 0);
         check_val("resp_rdata", src ? data_if.rdata : inst_if.rdata, rdata);
      end
   endtask

   task automatic expect_no_resp(input string tag);
      $display("DROP %s", tag);
      check_val({tag, "_inst_dok"}, inst_if.data_ok, 0);
      check_val({tag, "_data_dok"}, data_if.data_ok, 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      inst_if.req = 0; data_if.req = 0;
      bus_if.addr_ok = 0; bus_if.data_ok = 0; bus_if.rdata = '0;
      @(posedge clk); #1;
      resetn = 1'b1;
      exp_q.delete();
   endtask

   task automatic drain(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         drive(0, IA, 0, DA, 0, 1, base + k);
         expect_resp(base + k);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn          = 1'b0;
      inst_if.req     = 0; inst_if.wr = 0; inst_if.size = 2'd2;
      inst_if.addr    = '0; inst_if.wdata = I_WDATA;
      data_if.req     = 0; data_if.wr = 1; data_if.size = 2'd1;
      data_if.addr    = '0; data_if.wdata = D_WDATA;
      bus_if.addr_ok  = 0; bus_if.data_ok = 0; bus_if.rdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_bus_req",  bus_if.req,  0);
      check_val("rst_bus_addr", bus_if.addr, 0);
      check_val("rst_bus_wr",   bus_if.wr,   0);
      expect_no_resp("rst");
      @(posedge clk); #1;
      resetn = 1'b1;

      // Beat with nothing outstanding is ignored
      drive(0, IA, 0, DA, 0, 1, 32'hDEAD_BEEF);
      expect_no_resp("empty_beat");

      // Single instruction fetch
      drive(1, IA, 0, DA, 1, 0, 0);
      expect_hs(0, IA);
      drive(0, IA, 0, DA, 0, 0, 0);
      expect_blocked("t1_idle");
      drive(0, IA, 0, DA, 0, 1, 32'h3C1A_0001);
      expect_resp(32'h3C1A_0001);

      // Both request together: data first, inst next
      drive(1, IA + 4, 1, DA, 1, 0, 0);
      expect_hs(1, DA);
      drive(1, IA + 4, 0, DA, 1, 0, 0);
      expect_hs(0, IA + 4);
      drain(2, 32'h0000_2000);

      // Inst address phase stalled; data_req raised mid-stall must wait
      drive(1, IA + 8, 0, DA + 4, 0, 0, 0);
      check_val("t3_c0_addr", bus_if.addr, IA + 8);
      check_val("t3_c0_iaok", inst_if.addr_ok, 0);
      for (int c = 1; c < 3; c++) begin
         drive(1, IA + 8, 1, DA + 4, 0, 0, 0);
         check_val("t3_lock_addr", bus_if.addr, IA + 8);
         check_val("t3_lock_daok", data_if.addr_ok, 0);
      end
      drive(1, IA + 8, 1, DA + 4, 1, 0, 0);
      expect_hs(0, IA + 8);
      drive(0, IA + 8, 1, DA + 4, 1, 0, 0);
      expect_hs(1, DA + 4);
      drain(2, 32'h0000_3000);

      // Fill to MAX_OUT, fifth request blocked until one beat returns
      for (int k = 0; k < 4; k++) begin
         drive(k[0], IA + 32'h10 + 4 * k, !k[0], DA + 32'h10 + 4 * k, 1, 0, 0);
         expect_hs(!k[0], k[0] ? IA + 32'h10 + 4 * k : DA + 32'h10 + 4 * k);
      end
      drive(1, IA + 32'h40, 0, DA, 1, 0, 0);
      expect_blocked("t4_full");
      drive(1, IA + 32'h40, 0, DA, 0, 1, 32'h0000_4000);
      expect_resp(32'h0000_4000);
      check_val("t4_still_full", bus_if.req, 0);
      drive(1, IA + 32'h40, 0, DA, 1, 0, 0);
      expect_hs(0, IA + 32'h40);
      drain(4, 32'h0000_4100);

      // Handshake and beat in the same cycle keep the count
      drive(0, IA, 1, DA + 32'h20, 1, 0, 0);
      expect_hs(1, DA + 32'h20);
      drive(1, IA + 32'h20, 0, DA, 1, 0, 0);
      expect_hs(0, IA + 32'h20);
      drive(0, IA, 1, DA + 32'h24, 1, 1, 32'h0000_5000);
      expect_resp(32'h0000_5000);
      expect_hs(1, DA + 32'h24);
      drive(1, IA + 32'h24, 0, DA, 1, 0, 0);
      expect_hs(0, IA + 32'h24);
      drive(0, IA, 1, DA + 32'h28, 1, 0, 0);
      expect_hs(1, DA + 32'h28);
      drive(1, IA + 32'h28, 0, DA, 1, 0, 0);
      expect_blocked("t5_full");
      drain(4, 32'h0000_5100);

      // Reset with three outstanding: late beats dropped, full depth available again
      for (int k = 0; k < 3; k++) begin
         drive(!k[0], IA + 32'h30 + 4 * k, k[0], DA + 32'h30 + 4 * k, 1, 0, 0);
         expect_hs(k[0], k[0] ? DA + 32'h30 + 4 * k : IA + 32'h30 + 4 * k);
      end
      pulse_reset();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         drive(0, IA, 0, DA, 0, 1, 32'h0000_6000 + k);
         expect_no_resp("post_rst_beat");
      end
      for (int k = 0; k < 4; k++) begin
         drive(1, IA + 32'h50 + 4 * k, 0, DA, 1, 0, 0);
         expect_hs(0, IA + 32'h50 + 4 * k);
      end
      drive(1, IA + 32'h60, 0, DA, 1, 0, 0);
      expect_blocked("t6_full");
      drain(4, 32'h0000_6100);

      // Both requesters pending continuously
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         bit exp_src;
`ifdef ARB_ROUND_ROBIN_EN
         exp_src = !k[0];
`else
         exp_src = 1'b1;
`endif
         drive(1, IA + 32'h70 + 4 * k, 1, DA + 32'h70 + 4 * k, 1, 0, 0);
         expect_hs(exp_src, exp_src ? DA + 32'h70 + 4 * k : IA + 32'h70 + 4 * k);
      end
      drain(4, 32'h0000_7000);

      drive(0, IA, 0, DA, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
